// File: rtl/prbs_seq_detector.sv
// rtl/prbs_seq_detector.sv - Fibonacci-LFSR PRBS source with serial pattern detector and saturating match counter
module prbs_seq_detector #(
    parameter int                    LFSR_WIDTH = 21,
    parameter logic [LFSR_WIDTH-1:0] TAPS       = 21'h140000,
    parameter logic [LFSR_WIDTH-1:0] SEED       = 21'h000001,
    parameter int                    PAT_WIDTH  = 4,
    parameter logic [PAT_WIDTH-1:0]  PATTERN    = 4'b1011,
    parameter int                    CNT_WIDTH  = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sh_en,
    input  logic                 src_sel,
    input  logic                 din,
    input  logic                 overlap_en,
    input  logic                 clr_cnt,
    output logic                 lfsr_msb,
    output logic                 seq_detected,
    output logic [CNT_WIDTH-1:0] counter,
    output logic                 cnt_sat,
    output logic                 max_tick_reg
);

    localparam int FW = $clog2(PAT_WIDTH + 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(PAT_WIDTH);

    typedef enum logic {S_FILL, S_ARMED} det_state_t;

    logic [LFSR_WIDTH-1:0] lfsr, lfsr_nxt;
    logic [PAT_WIDTH-1:0]  hist, hist_nxt, hist_sh;
    logic [FW-1:0]         fill, fill_nxt, fill_inc;
    logic                  src_q;
    logic                  det_nxt, tick_nxt, match, bit_in, fb;
    logic [CNT_WIDTH-1:0]  cnt_nxt;
    logic                  sat_nxt;
    det_state_t            state;

    assign lfsr_msb = lfsr[LFSR_WIDTH-1];
    assign state    = (fill == FILL_FULL) ? S_ARMED : S_FILL;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr         <= SEED;
            hist         <= '0;
            fill         <= '0;
            src_q        <= src_sel;
            seq_detected <= 1'b0;
            counter      <= '0;
            cnt_sat      <= 1'b0;
            max_tick_reg <= 1'b0;
        end else begin
            lfsr         <= lfsr_nxt;
            hist         <= hist_nxt;
            fill         <= fill_nxt;
            src_q        <= src_sel;
            seq_detected <= det_nxt;
            counter      <= cnt_nxt;
            cnt_sat      <= sat_nxt;
            max_tick_reg <= tick_nxt;
        end
    end

    always_comb begin
        lfsr_nxt = lfsr;
        hist_nxt = hist;
        fill_nxt = fill;
        det_nxt  = 1'b0;
        tick_nxt = 1'b0;
        match    = 1'b0;
        cnt_nxt  = counter;
        sat_nxt  = cnt_sat;
        bit_in   = src_sel ? din : lfsr[LFSR_WIDTH-1];
        fb       = ^(lfsr & TAPS);
        hist_sh  = {hist[PAT_WIDTH-2:0], bit_in};
        fill_inc = (state == S_ARMED) ? fill : fill + FW'(1);

        // An all-zero register would never leave lock-up, so it is reseeded.
        if (sh_en) begin
            lfsr_nxt = (lfsr == '0) ? SEED : {lfsr[LFSR_WIDTH-2:0], fb};
            tick_nxt = (lfsr_nxt == SEED);
        end

        // A source change invalidates the history collected so far.
        if (src_q != src_sel) begin
            fill_nxt = '0;
        end else if (sh_en) begin
            hist_nxt = hist_sh;
            match    = (fill_inc == FILL_FULL) && (hist_sh == PATTERN);
            fill_nxt = (match && !overlap_en) ? '0 : fill_inc;
            det_nxt  = match;
        end

        if (clr_cnt) begin
            cnt_nxt = '0;
            sat_nxt = 1'b0;
        end else if (match && (counter != '1)) begin
            cnt_nxt = counter + CNT_WIDTH'(1);
            if (cnt_nxt == '1) begin
                sat_nxt = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prbs_seq_detector.sv
// tb/tb_prbs_seq_detector.sv - randomized and directed bench for prbs_seq_detector against a queue-based reference
module tb_prbs_seq_detector;

    localparam logic [3:0] TAPS    = 4'b1100;
    localparam logic [3:0] SEED    = 4'b0001;
    localparam logic [3:0] PATTERN = 4'b1011;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sh_en = 1'b0;
    logic       src_sel = 1'b0;
    logic       din = 1'b0;
    logic       overlap_en = 1'b0;
    logic       clr_cnt = 1'b0;
    logic       lfsr_msb;
    logic       seq_detected;
    logic [1:0] counter;
    logic       cnt_sat;
    logic       max_tick_reg;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] m_lfsr;
    bit         m_q[$];
    logic       m_det, m_sat, m_tick, m_src;
    int         m_cnt;
    int         cycle, n_ticks, first_tick;

    prbs_seq_detector #(
        .LFSR_WIDTH(4), .TAPS(TAPS), .SEED(SEED),
        .PAT_WIDTH(4), .PATTERN(PATTERN), .CNT_WIDTH(2)
    ) dut (
        .clk(clk), .rst(rst), .sh_en(sh_en), .src_sel(src_sel), .din(din),
        .overlap_en(overlap_en), .clr_cnt(clr_cnt), .lfsr_msb(lfsr_msb),
        .seq_detected(seq_detected), .counter(counter), .cnt_sat(cnt_sat),
        .max_tick_reg(max_tick_reg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: bits collected since the last restart live in a queue;
    // a match is simply "the newest four bits spell PATTERN".
    task automatic model_edge();
        bit   b, match;
        logic [3:0] nxt, win;
        match = 1'b0;
        if (rst) begin
            m_lfsr = SEED; m_q.delete(); m_det = 0; m_cnt = 0; m_sat = 0; m_tick = 0;
            m_src = src_sel;
            return;
        end
        b = src_sel ? din : m_lfsr[3];
        m_tick = 1'b0;
        if (sh_en) begin
            if (m_lfsr == 0) nxt = SEED;
            else nxt = {m_lfsr[2:0], 1'(($countones(m_lfsr & TAPS) % 2))};
            m_tick = (nxt == SEED);
            m_lfsr = nxt;
        end
        if (src_sel != m_src) begin
            m_q.delete();
        end else if (sh_en) begin
            m_q.push_back(b);
            if (m_q.size() > 4) void'(m_q.pop_front());
            if (m_q.size() == 4) begin
                for (int i = 0; i < 4; i++) win[3-i] = m_q[i];
                if (win == PATTERN) begin
                    match = 1'b1;
                    if (!overlap_en) m_q.delete();
                end
            end
        end
        m_det = match;
        if (clr_cnt) begin
            m_cnt = 0; m_sat = 0;
        end else if (match && m_cnt != 3) begin
            m_cnt++;
            if (m_cnt == 3) m_sat = 1;
        end
        m_src = src_sel;
    endtask

    task automatic step(input logic r, input logic se, input logic ss, input logic d,
                        input logic ov, input logic cc);
        @(negedge clk);
        rst = r; sh_en = se; src_sel = ss; din = d; overlap_en = ov; clr_cnt = cc;
        @(posedge clk);
        model_edge();
        #1;
        cycle++;
        if (max_tick_reg === 1'b1) begin
            n_ticks++;
            if (first_tick < 0) first_tick = cycle;
        end
        check("lfsr_msb", 32'(lfsr_msb), 32'(m_lfsr[3]));
        check("seq_detected", 32'(seq_detected), 32'(m_det));
        check("counter", 32'(counter), 32'(m_cnt));
        check("cnt_sat", 32'(cnt_sat), 32'(m_sat));
        check("max_tick_reg", 32'(max_tick_reg), 32'(m_tick));
    endtask

    task automatic feed(input logic [15:0] bits, input int n, input logic ov);
        for (int i = n - 1; i >= 0; i--) step(0, 1, 1, bits[i], ov, 0);
    endtask

    initial begin
        logic ss;
        m_lfsr = SEED; m_det = 0; m_cnt = 0; m_sat = 0; m_tick = 0; m_src = 0;
        first_tick = -1; n_ticks = 0; cycle = 0;

        // Reset held two cycles, then a full three LFSR periods.
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        check("reset_msb", 32'(lfsr_msb), 32'd0);
        check("reset_cnt", 32'(counter), 32'd0);
        cycle = 0; n_ticks = 0; first_tick = -1;
        for (int i = 0; i < 45; i++) step(0, 1, 0, 0, 1, 0);
        check("first_tick_cycle", 32'(first_tick), 32'd15);
        check("tick_count_45", 32'(n_ticks), 32'd3);

        // Overlap: 1011011 gives two pulses.
        step(1, 0, 1, 0, 1, 0);
        feed(16'b1011011, 7, 1);
        check("overlap_count", 32'(counter), 32'd2);

        // Non-overlap: same stream gives one pulse.
        step(1, 0, 1, 0, 0, 0);
        feed(16'b1011011, 7, 0);
        check("nonoverlap_count", 32'(counter), 32'd1);

        // Enable gap of three cycles between bits 2 and 3.
        step(1, 0, 1, 0, 0, 0);
        feed(16'b10, 2, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1'($urandom_range(0, 1)), 0, 0);
        feed(16'b11011, 5, 0);
        check("gap_count", 32'(counter), 32'd1);

        // Saturation, then clear with a simultaneous match.
        step(1, 0, 1, 0, 1, 0);
        feed(16'b1011011011, 10, 1);
        check("sat_count3", 32'(counter), 32'd3);
        check("sat_flag", 32'(cnt_sat), 32'd1);
        feed(16'b011, 3, 1);
        check("sat_4th_pulse", 32'(seq_detected), 32'd1);
        check("sat_hold", 32'(counter), 32'd3);
        feed(16'b01, 2, 1);
        step(0, 1, 1, 1, 1, 1);
        check("clr_match_pulse", 32'(seq_detected), 32'd1);
        check("clr_count", 32'(counter), 32'd0);
        check("clr_sat", 32'(cnt_sat), 32'd0);

        // Source switch mid-stream, then reset with a pending match.
        step(1, 0, 1, 0, 1, 0);
        feed(16'b101, 3, 1);
        step(0, 1, 0, 1, 1, 0);
        check("switch_no_pulse", 32'(seq_detected), 32'd0);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 1, 0);
        step(0, 0, 1, 0, 1, 0);
        feed(16'b101, 3, 1);
        step(1, 1, 1, 1, 1, 0);
        check("rst_no_pulse", 32'(seq_detected), 32'd0);
        check("rst_msb", 32'(lfsr_msb), 32'(SEED[3]));

        // Randomized run.
        ss = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) ss = ~ss;
            step(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 3) != 0), ss,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 31) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/prbs_seq_detector.md
# prbs_seq_detector

Parametrised successor to the fixed-width LFSR sequence-detector top. It generates a maximal-length PRBS from a Fibonacci LFSR of configurable width, taps and seed. The serial stream, or an external serial input, is scanned for a configurable pattern in overlapping or non-overlapping mode. Matches are counted in a saturating counter. The block also flags each completed LFSR period, and is the stimulus/checker core used by the FSM test benches.

## Interface
- LFSR_WIDTH, 21, LFSR length in bits (≥3)
- TAPS, 21'h140000, feedback mask; bit i set = stage i+1 tapped (default x^21+x^19+1)
- SEED, 21'h000001, reset/reload value; must be nonzero
- PAT_WIDTH, 4, pattern length (2..16)
- PATTERN, 4'b1011, pattern to detect; MSB is the oldest bit
- CNT_WIDTH, 9, match counter width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- sh_en  in  1  shift enable; the LFSR and detector advance only when high
- src_sel  in  1  0 = detect on lfsr_msb; 1 = detect on din
- din  in  1  external serial bit, sampled when sh_en=1
- overlap_en  in  1  1 = overlapping matches allowed
- clr_cnt  in  1  synchronous clear of counter and cnt_sat
- lfsr_msb  out  1  lfsr[LFSR_WIDTH-1]
- seq_detected  out  1  one-cycle registered match pulse
- counter  out  CNT_WIDTH  match count
- cnt_sat  out  1  sticky; counter has reached all-ones
- max_tick_reg  out  1  one-cycle pulse at end of each LFSR period

## Operation
- **LFSR.** On an edge with sh_en=1: fb = ^(lfsr & TAPS); lfsr <= {lfsr[W-2:0], fb}.
  - If lfsr == 0 (lock-up), reload SEED instead of shifting.
- **Serial bit.** b = src_sel ? din : lfsr_msb, both taken pre-shift.
- **Detector registers.** History register hist[PAT_WIDTH-1:0] and fill count fill[0..PAT_WIDTH]. The fill count is the FSM:
  - FILL: fill < PAT_WIDTH.
  - ARMED: fill = PAT_WIDTH.
- **Each enabled edge:**
  - h' = {hist[PAT_WIDTH-2:0], b}; f' = min(fill+1, PAT_WIDTH).
  - match = (f' == PAT_WIDTH) && (h' == PATTERN).
  - hist <= h'.
  - fill <= (match && !overlap_en) ? 0 : f'. Non-overlap re-enters FILL.
  - seq_detected <= match.
- **Disabled edge (sh_en=0):** LFSR, hist and fill hold; seq_detected <= 0.
- **src_sel change.** src_sel is registered internally. If the registered value differs from the current input at an edge, that edge sets fill <= 0 and seq_detected <= 0 with no match evaluation. This applies whether or not sh_en is high. The LFSR still shifts if sh_en=1.
- **Counter.**
  - clr_cnt=1: counter <= 0, cnt_sat <= 0. Clear has priority over increment.
  - Otherwise, on match with counter != all-ones: counter increments.
  - cnt_sat <= 1 when counter becomes all-ones and stays set until clr_cnt or rst. Further matches leave counter at all-ones; seq_detected still pulses.
- **Period flag.** max_tick_reg <= 1 on an enabled edge whose next LFSR state equals SEED, otherwise 0. With maximal TAPS this gives one pulse every 2^LFSR_WIDTH−1 enabled cycles.

## Timing
- **Reset values (rst=1 at an edge):** lfsr=SEED, hist=0, fill=0, seq_detected=0, counter=0, cnt_sat=0, max_tick_reg=0.
  - lfsr_msb = SEED[W-1].
  - The internal src_sel register loads the current src_sel.
- **Reset mid-operation** takes effect at the same edge and discards any pending match.
- **Latency:** seq_detected, counter and max_tick_reg all update on the same edge that consumes the final pattern bit. They are visible one cycle after the bit is presented.
- **First possible match:** the PAT_WIDTH-th enabled edge after reset.
- **Non-overlap mode:** at least PAT_WIDTH enabled edges between matches.
- **Overlap mode:** back-to-back pulses are possible when PATTERN permits.
- **sh_en toggling** stretches time but does not alter the bit sequence or the detection outcome.
- **Throughput:** one bit per clock.

## Test plan
- **Reset/seed.** LFSR_WIDTH=4, TAPS=4'b1100, SEED=4'b0001; rst for 2 cycles.
  - During and after reset: lfsr_msb=0, counter=0, seq_detected=0, max_tick_reg=0.
  - After release with sh_en=1: max_tick_reg pulses exactly every 15 cycles, first on cycle 15.
  - All 15 nonzero states are visited once per period.
- **Overlap detect.** src_sel=1, overlap_en=1, PATTERN=1011; din=1,0,1,1,0,1,1.
  - seq_detected pulses after bits 4 and 7; counter=2.
- **Non-overlap detect.** Same stream with overlap_en=0.
  - Single pulse after bit 4; counter=1.
  - Bits 5–7 fill only 3 of 4 slots, so no second pulse.
- **Enable gaps.** Same stream with sh_en=0 for 3 cycles between bits 2 and 3.
  - Pulse is delayed by 3 cycles; counter=1 in non-overlap mode.
  - lfsr holds during the gap.
- **Saturation/clear.** CNT_WIDTH=2; drive 4 matches.
  - counter=3 after the 3rd match and cnt_sat=1.
  - 4th match: seq_detected pulses, counter stays 3.
  - clr_cnt plus a simultaneous match gives counter=0, cnt_sat=0.
- **Source switch/reset mid-stream.**
  - Toggle src_sel after din=1,0,1: no pulse on that edge, fill restarts, and a pattern needs 4 new bits.
  - Assert rst while hist=101 with the next bit 1: no pulse, and all outputs return to reset values.
